vec_int_ctrl: RTL and testbench
===============================

VEC_INT_CTRL -- requirements
Module: vec_int_ctrl

Interface
REQ-001 The module SHALL provide parameter NCH, default 4, meaning the number of interrupt channels (1..16).
REQ-002 The module SHALL provide parameter VW, default 8, meaning the vector width in bits.
REQ-003 The module SHALL provide parameter VEC_BASE, default 8'hE0, meaning the vector of channel 0.
REQ-004 The module SHALL provide parameter VEC_STRIDE, default 4, meaning the vector spacing between adjacent channels.
REQ-005 The module SHALL provide port t3, input, 1 bit: machine-cycle clock; all state updates on its falling edge.
REQ-006 The module SHALL provide port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL provide port irq, input, NCH bits: interrupt sources, edge-triggered on a 0->1 transition.
REQ-008 The module SHALL provide port mask, input, NCH bits: 1 blocks a channel from requesting; its pending bit is kept.
REQ-009 The module SHALL provide port inten, input, 1 bit: sets en_int (IRET beat).
REQ-010 The module SHALL provide port intdi, input, 1 bit: clears en_int (interrupt-entry beat).
REQ-011 The module SHALL provide port int_ack, input, 1 bit: CPU accepts the current request.
REQ-012 The module SHALL provide port iret, input, 1 bit: end of the current service routine.
REQ-013 The module SHALL provide port int_req, output, 1 bit: interrupt request to the sequencer.
REQ-014 The module SHALL provide port vector, output, VW bits: entry address of the granted channel.
REQ-015 The module SHALL provide port en_int, output, 1 bit: global interrupt enable.
REQ-016 The module SHALL provide port pending, output, NCH bits: latched, unserviced edges.
REQ-017 The module SHALL provide port in_service, output, NCH bits: channels currently being serviced.

Function
REQ-018 The block SHALL register irq each edge into irq_d and set pending[i] at the edge where irq[i]=1 and irq_d[i]=0.
REQ-019 The block SHALL define priority as lowest index highest, and SHALL select win = lowest i with pending[i] & ~mask[i].
REQ-020 The block SHALL implement FSM states IDLE, REQ, SERV, entered from IDLE on reset.
REQ-021 On the edge where the state is IDLE, a win exists and en_int=1, the state SHALL become REQ and int_req SHALL be 1 (registered, one cycle after pending).
REQ-022 In REQ, on the edge with int_ack=1, the block SHALL latch vector = VEC_BASE + win*VEC_STRIDE (mod 2^VW), clear pending[win], set in_service[win], drop int_req, and enter SERV.
REQ-023 In REQ, if win disappears (masked) before int_ack, the block SHALL drop int_req and return to IDLE.
REQ-024 In SERV, on the edge with iret=1, the block SHALL clear the highest-priority set in_service bit; the state SHALL become IDLE once in_service is all-zero.
REQ-025 The block SHALL update en_int as en_int <= inten | (en_int & ~intdi); inten SHALL win when both are asserted.
REQ-026 The block SHALL ignore int_ack outside REQ and iret when in_service is zero.
REQ-027 A new edge on a channel already pending SHALL be absorbed (no count); an edge arriving on the int_ack edge for the granted channel SHALL leave pending set.
REQ-028 vector SHALL hold its value until the next accepted int_ack.

Reset
REQ-029 While clr=0, the block SHALL hold state=IDLE, int_req=0, vector=0, en_int=1, pending=0, in_service=0, irq_d=0.
REQ-030 clr asserted mid-REQ or mid-SERV SHALL abandon the service with no further int_req until a new edge occurs.

Configuration
REQ-031 With NESTED_INT_EN defined, in SERV a win of higher priority than every set in_service bit, with en_int=1, SHALL reassert int_req and enter REQ; the ack SHALL stack another in_service bit, and the state SHALL return to SERV.
REQ-032 Without NESTED_INT_EN, the block SHALL make no request from SERV, and in_service SHALL never have more than one bit set.

Verification
REQ-033 Reset, then irq=4'b0100 -> pending=4'b0100 next edge, int_req=1 one edge later; int_ack -> vector=8'hE8, in_service=4'b0100, int_req=0.
REQ-034 Simultaneous irq=4'b1010 -> ack grants channel 1 (vector=8'hE4); channel 3 remains pending and is granted after iret.
REQ-035 mask=4'b0001 with irq[0] edge -> no int_req, pending[0]=1; mask cleared -> int_req next edge.
REQ-036 intdi=1 then irq edge -> no int_req; inten=1 and intdi=1 on the same edge -> en_int=1.
REQ-037 NESTED_INT_EN: serving ch2, irq[0] edge -> int_req, ack gives vector=8'hE0, in_service=4'b0101; first iret clears bit 0 only.
REQ-038 clr pulsed in SERV -> all outputs at reset values, en_int=1, no request until a fresh edge.

Source files
------------

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: edge-latched requests, fixed priority (lowest index wins), vector on ack.
// Define NESTED_INT_EN to let a higher-priority source preempt a routine in service.
//
// state | meaning
// IDLE  | nothing requested, nothing in service
// REQ   | int_req raised, waiting for int_ack
// SERV  | at least one channel in service, waiting for iret
module vec_int_ctrl #(
  parameter int          NCH        = 4,
  parameter int          VW         = 8,
  parameter int unsigned VEC_BASE   = 32'hE0,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic           t3,
  input  logic           clr,
  input  logic [NCH-1:0] irq,
  input  logic [NCH-1:0] mask,
  input  logic           inten,
  input  logic           intdi,
  input  logic           int_ack,
  input  logic           iret,
  output logic           int_req,
  output logic [VW-1:0]  vector,
  output logic           en_int,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] in_service
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV} state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] irq_d_q;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] in_service_q, in_service_d;
  logic [VW-1:0]  vector_q, vector_d;
  logic           en_int_q, en_int_d;

  logic [NCH-1:0] edge_v, cand, win_oh, isr_lo;
  logic           win_vld, ack_go, iret_go;
  logic [IW-1:0]  win_idx;
  logic [31:0]    vec_sum;

  assign edge_v  = irq & ~irq_d_q;
  assign cand    = pending_q & ~mask;
  assign win_vld = |cand;
  // Two's-complement trick isolates the lowest set bit of each vector.
  assign win_oh  = cand & (~cand + NCH'(1));
  assign isr_lo  = in_service_q & (~in_service_q + NCH'(1));

`ifdef NESTED_INT_EN
  logic [NCH-1:0] win_le;
  logic           nest_ok;
  assign win_le  = win_oh | (win_oh - NCH'(1));
  assign nest_ok = win_vld && en_int_q && ((in_service_q & win_le) == '0);
`endif

  always_comb begin
    win_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IW'(i);
    end
  end

  assign ack_go  = (state_q == S_REQ) && win_vld && int_ack;
  assign iret_go = (state_q == S_SERV) && iret && (|in_service_q);
  assign vec_sum = VEC_BASE + 32'(win_idx) * VEC_STRIDE;

  always_ff @(negedge t3 or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_vld && en_int_q) state_d = S_REQ;
      S_REQ: begin
        if (!win_vld)     state_d = (|in_service_q) ? S_SERV : S_IDLE;
        else if (int_ack) state_d = S_SERV;
      end
      S_SERV: begin
        if (iret_go) begin
          if ((in_service_q & ~isr_lo) == '0) state_d = S_IDLE;
        end
`ifdef NESTED_INT_EN
        else if (nest_ok) state_d = S_REQ;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_req = (state_q == S_REQ);
  end

  // A fresh edge on the granted channel in the ack cycle re-arms its pending bit.
  always_comb begin
    pending_d    = (pending_q & ~(ack_go ? win_oh : '0)) | edge_v;
    in_service_d = in_service_q;
    if (ack_go)  in_service_d = in_service_q | win_oh;
    if (iret_go) in_service_d = in_service_q & ~isr_lo;
    vector_d     = ack_go ? vec_sum[VW-1:0] : vector_q;
    en_int_d     = inten | (en_int_q & ~intdi);
  end

  always_ff @(negedge t3 or negedge clr) begin
    if (!clr) begin
      irq_d_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      vector_q     <= '0;
      en_int_q     <= 1'b1;
    end else begin
      irq_d_q      <= irq;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      vector_q     <= vector_d;
      en_int_q     <= en_int_d;
    end
  end

  assign vector     = vector_q;
  assign en_int     = en_int_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Bench for vec_int_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_vec_int_ctrl;

  logic       t3 = 1'b0;
  logic       clr;
  logic [3:0] irq, mask;
  logic       inten, intdi, int_ack, iret;
  logic       int_req, en_int;
  logic [7:0] vector;
  logic [3:0] pending, in_service;

  always #5 t3 = ~t3;

  vec_int_ctrl #(.NCH(4), .VW(8), .VEC_BASE(32'hE0), .VEC_STRIDE(4)) dut (
    .t3(t3), .clr(clr), .irq(irq), .mask(mask), .inten(inten), .intdi(intdi),
    .int_ack(int_ack), .iret(iret), .int_req(int_req), .vector(vector),
    .en_int(en_int), .pending(pending), .in_service(in_service)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending set, list of channels in service, request flag.
  bit [3:0] m_pend, m_prev;
  int       m_svc[$];
  bit       m_req, m_en;
  bit [7:0] m_vec;

  function automatic int lowest(input bit [3:0] v);
    lowest = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) lowest = i;
  endfunction

  function automatic bit [3:0] svc_bits();
    bit [3:0] b = '0;
    foreach (m_svc[k]) b[m_svc[k]] = 1'b1;
    return b;
  endfunction

  function automatic int svc_min();
    int mn = 99;
    foreach (m_svc[k]) if (m_svc[k] < mn) mn = m_svc[k];
    return mn;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_svc.delete(); m_req = 0; m_en = 1; m_vec = '0;
  endtask

  task automatic model_step();
    bit [3:0] rise;
    int       w, mi;
    if (!clr) model_reset();
    else begin
      rise = irq & ~m_prev;
      w    = lowest(m_pend & ~mask);
      if (m_req) begin
        if (w < 0) m_req = 0;
        else if (int_ack) begin
          m_vec = 8'((32'hE0 + w * 4) % 256);
          m_pend[w] = 1'b0;
          m_svc.push_back(w);
          m_req = 0;
        end
      end else if (m_svc.size() > 0) begin
        if (iret) begin
          mi = 0;
          foreach (m_svc[k]) if (m_svc[k] < m_svc[mi]) mi = k;
          m_svc.delete(mi);
        end
`ifdef NESTED_INT_EN
        else if (w >= 0 && m_en && w < svc_min()) m_req = 1;
`endif
      end else if (w >= 0 && m_en) m_req = 1;
      m_pend = m_pend | rise;
      m_en   = inten | (m_en & ~intdi);
      m_prev = irq;
    end
  endtask

  task automatic compare_all();
    chk("int_req",    32'(int_req),    32'(m_req));
    chk("vector",     32'(vector),     32'(m_vec));
    chk("en_int",     32'(en_int),     32'(m_en));
    chk("pending",    32'(pending),    32'(m_pend));
    chk("in_service", 32'(in_service), 32'(svc_bits()));
  endtask

  task automatic cycle();
    @(negedge t3);
    model_step();
    @(posedge t3);
    compare_all();
  endtask

  task automatic pulse_ack();
    int_ack = 1; cycle(); int_ack = 0;
  endtask

  task automatic pulse_iret();
    iret = 1; cycle(); iret = 0;
  endtask

  initial begin
    clr = 0; irq = '0; mask = '0; inten = 0; intdi = 0; int_ack = 0; iret = 0;
    model_reset();
    cycle(); cycle();
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_vector",  32'(vector), 32'd0);
    chk("rst_en_int",  32'(en_int), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_in_serv", 32'(in_service), 32'd0);
    clr = 1;
    cycle();

    // Single source on channel 2.
    irq = 4'b0100; cycle();
    chk("c2_pending", 32'(pending), 32'h4);
    chk("c2_noreq_yet", 32'(int_req), 32'd0);
    cycle();
    chk("c2_req", 32'(int_req), 32'd1);
    pulse_ack();
    chk("c2_vector", 32'(vector), 32'hE8);
    chk("c2_in_serv", 32'(in_service), 32'h4);
    chk("c2_req_drop", 32'(int_req), 32'd0);
    irq = '0;
    pulse_iret();
    chk("c2_iret", 32'(in_service), 32'h0);
    cycle();

    // Simultaneous channels 1 and 3.
    irq = 4'b1010; cycle(); cycle();
    pulse_ack();
    chk("pri_vector", 32'(vector), 32'hE4);
    chk("pri_pend3", 32'(pending), 32'h8);
    irq = '0;
    pulse_iret();
    cycle();
    chk("pri_req3", 32'(int_req), 32'd1);
    pulse_ack();
    chk("pri_vec3", 32'(vector), 32'hEC);
    chk("pri_hold", 32'(vector), 32'hEC);
    pulse_iret();
    cycle();

    // Masked channel 0 keeps its pending bit.
    mask = 4'b0001; irq = 4'b0001; cycle(); cycle(); cycle();
    chk("mask_noreq", 32'(int_req), 32'd0);
    chk("mask_pend", 32'(pending), 32'h1);
    mask = '0; cycle();
    chk("unmask_req", 32'(int_req), 32'd1);
    pulse_ack();
    chk("unmask_vec", 32'(vector), 32'hE0);
    irq = '0;
    pulse_iret();
    cycle();

    // Masking the winner while requesting withdraws the request.
    irq = 4'b0010; cycle(); cycle();
    chk("wd_req", 32'(int_req), 32'd1);
    mask = 4'b0010; cycle();
    chk("wd_drop", 32'(int_req), 32'd0);
    mask = '0; irq = '0; cycle(); pulse_ack(); pulse_iret(); cycle();

    // Global enable.
    intdi = 1; cycle(); intdi = 0;
    chk("dis_en", 32'(en_int), 32'd0);
    irq = 4'b0010; cycle(); cycle(); cycle();
    chk("dis_noreq", 32'(int_req), 32'd0);
    inten = 1; intdi = 1; cycle(); inten = 0; intdi = 0;
    chk("both_en", 32'(en_int), 32'd1);
    cycle();
    chk("en_req", 32'(int_req), 32'd1);
    pulse_ack(); irq = '0; pulse_iret(); cycle();

    // Higher-priority edge while channel 2 is in service.
    irq = 4'b0100; cycle(); cycle(); pulse_ack();
    irq = 4'b0101; cycle(); cycle();
`ifdef NESTED_INT_EN
    chk("nest_req", 32'(int_req), 32'd1);
    pulse_ack();
    chk("nest_vec", 32'(vector), 32'hE0);
    chk("nest_isr", 32'(in_service), 32'h5);
    pulse_iret();
    chk("nest_iret1", 32'(in_service), 32'h4);
    pulse_iret();
`else
    chk("nonest_noreq", 32'(int_req), 32'd0);
    chk("nonest_isr", 32'(in_service), 32'h4);
    pulse_iret();
    cycle();
    chk("nonest_after", 32'(int_req), 32'd1);
    pulse_ack();
    chk("nonest_vec", 32'(vector), 32'hE0);
    pulse_iret();
`endif
    irq = '0; cycle();

    // Reset in SERV with the enable cleared.
    irq = 4'b0010; cycle(); cycle(); pulse_ack();
    irq = '0; intdi = 1; cycle(); intdi = 0;
    clr = 0; #1;
    chk("clr_req", 32'(int_req), 32'd0);
    chk("clr_isr", 32'(in_service), 32'd0);
    chk("clr_en", 32'(en_int), 32'd1);
    chk("clr_vec", 32'(vector), 32'd0);
    chk("clr_pend", 32'(pending), 32'd0);
    cycle();
    clr = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("clr_quiet", 32'(int_req), 32'd0);
    end
    irq = 4'b0001; cycle(); cycle();
    chk("clr_fresh_req", 32'(int_req), 32'd1);
    pulse_ack(); irq = '0; pulse_iret(); cycle();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0)
        mask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      inten   = ($urandom_range(0, 29) == 0);
      intdi   = ($urandom_range(0, 29) == 0);
      int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      iret    = (m_svc.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      clr     = ($urandom_range(0, 399) != 0);
      cycle();
`ifndef NESTED_INT_EN
      chk("isr_onehot", 32'($countones(in_service) <= 1), 32'd1);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
